// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state encoding, instruction constants and the 1149.1 next-state function.
// Used by jtag_sampled_tap (and its optional JTAG_SAMPLED_TAP_TRST_EN build).
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'h0,
        RUN_TEST_IDLE    = 4'h1,
        SELECT_DR        = 4'h2,
        CAPTURE_DR       = 4'h3,
        SHIFT_DR         = 4'h4,
        EXIT1_DR         = 4'h5,
        PAUSE_DR         = 4'h6,
        EXIT2_DR         = 4'h7,
        UPDATE_DR        = 4'h8,
        SELECT_IR        = 4'h9,
        CAPTURE_IR       = 4'hA,
        SHIFT_IR         = 4'hB,
        EXIT1_IR         = 4'hC,
        PAUSE_IR         = 4'hD,
        EXIT2_IR         = 4'hE,
        UPDATE_IR        = 4'hF
    } tap_state_t;

    localparam int          IDCODE_INSTR = 1;
    localparam int          USER_BASE    = 8;
    localparam logic [31:0] BYPASS_INSTR = '1;

    function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TEST_LOGIC_RESET;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        n = tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// jtag_pin_sync: multi-stage synchroniser for asynchronous pins with edge detect on bit 0.
// Ports: clk, rst_n (async active-low), d (raw pins), q (synchronised pins),
//        rise/fall (one-clk pulses on 0->1 / 1->0 of synchronised d[0]).
module jtag_pin_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rise,
    output logic             fall
);

    logic [WIDTH-1:0] sync [STAGES];
    logic             last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync[i] <= '0;
            last <= 1'b0;
        end else begin
            sync[0] <= d;
            for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
            last <= sync[STAGES-1][0];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q[0] & ~last;
    assign fall = ~q[0] & last;

endmodule

// File: rtl/jtag_sampled_tap.sv
// jtag_sampled_tap: IEEE 1149.1 TAP running entirely in the clk domain with oversampled tck/tms/tdi.
// Ports: clk, rst_n (async active-low); tck/tms/tdi pins in, tdo/tdo_oe out; tap_state, instruction;
//        user_dr_in/user_dr_out (channel n at [n*DR_WIDTH +: DR_WIDTH]), user_capture/user_update pulses.
// Optional: define JTAG_SAMPLED_TAP_TRST_EN to add the trst_n input (async active-low test reset).
module jtag_sampled_tap
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 5,
    parameter int          DR_WIDTH     = 32,
    parameter int          NUM_USER_DR  = 2,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_563D,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
`ifdef JTAG_SAMPLED_TAP_TRST_EN
    input  logic                            trst_n,
`endif
    input  logic                            tck,
    input  logic                            tms,
    input  logic                            tdi,
    output logic                            tdo,
    output logic                            tdo_oe,
    output logic [3:0]                      tap_state,
    output logic [IR_WIDTH-1:0]             instruction,
    input  logic [NUM_USER_DR*DR_WIDTH-1:0] user_dr_in,
    output logic [NUM_USER_DR*DR_WIDTH-1:0] user_dr_out,
    output logic [NUM_USER_DR-1:0]          user_capture,
    output logic [NUM_USER_DR-1:0]          user_update
);

    localparam logic [IR_WIDTH-1:0] IDCODE = IR_WIDTH'(IDCODE_INSTR);

    tap_state_t              state;
    logic [IR_WIDTH-1:0]     ir_sh;
    logic [DR_WIDTH-1:0]     dr_sh, cap_data;
    logic                    byp, tck_rise, tck_fall, tms_s, tdi_s, tck_s_unused, trst_act;
    logic [NUM_USER_DR-1:0]  user_sel;
    logic                    is_idcode, is_bypass;

    jtag_pin_sync #(.STAGES(SYNC_STAGES), .WIDTH(3)) u_pins (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({tdi, tms, tck}),
        .q    ({tdi_s, tms_s, tck_s_unused}),
        .rise (tck_rise),
        .fall (tck_fall)
    );

`ifdef JTAG_SAMPLED_TAP_TRST_EN
    logic trst_s, trst_rise_unused, trst_fall_unused;
    jtag_pin_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_trst (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (trst_n),
        .q    (trst_s),
        .rise (trst_rise_unused),
        .fall (trst_fall_unused)
    );
    assign trst_act = ~trst_s;
`else
    assign trst_act = 1'b0;
`endif

    // All-ones wins over a USERn code that happens to alias it for narrow IRs;
    // unknown codes fall through to BYPASS but instruction keeps the raw value.
    always_comb begin
        user_sel = '0;
        cap_data = DR_WIDTH'(IDCODE_VALUE);
        for (int n = 0; n < NUM_USER_DR; n++)
            if (instruction != IR_WIDTH'(BYPASS_INSTR) && instruction == IR_WIDTH'(USER_BASE + n)) begin
                user_sel[n] = 1'b1;
                cap_data    = user_dr_in[n*DR_WIDTH +: DR_WIDTH];
            end
    end

    assign is_idcode = instruction == IDCODE;
    assign is_bypass = !is_idcode && user_sel == '0;
    assign tap_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= TEST_LOGIC_RESET;
            instruction  <= IDCODE;
            ir_sh        <= '0;
            dr_sh        <= '0;
            byp          <= 1'b0;
            tdo          <= 1'b0;
            tdo_oe       <= 1'b0;
            user_dr_out  <= '0;
            user_capture <= '0;
            user_update  <= '0;
        end else begin
            user_capture <= '0;
            user_update  <= '0;
            if (trst_act) begin
                state       <= TEST_LOGIC_RESET;
                instruction <= IDCODE;
                tdo         <= 1'b0;
                tdo_oe      <= 1'b0;
            end else if (tck_rise) begin
                state <= next_state(state, tms_s);
                if (next_state(state, tms_s) == TEST_LOGIC_RESET) instruction <= IDCODE;
                if (state == CAPTURE_IR) ir_sh <= IR_WIDTH'(1);
                if (state == SHIFT_IR) ir_sh <= {tdi_s, ir_sh[IR_WIDTH-1:1]};
                if (state == CAPTURE_DR) begin
                    byp          <= 1'b0;
                    dr_sh        <= cap_data;
                    user_capture <= user_sel;
                end
                if (state == SHIFT_DR) begin
                    if (is_bypass) byp <= tdi_s;
                    else dr_sh <= {tdi_s, dr_sh[DR_WIDTH-1:1]};
                end
            end else if (tck_fall) begin
                tdo_oe <= state == SHIFT_IR || state == SHIFT_DR;
                tdo    <= state == SHIFT_IR ? ir_sh[0] :
                          state == SHIFT_DR ? (is_bypass ? byp : dr_sh[0]) : 1'b0;
                if (state == UPDATE_IR) instruction <= ir_sh;
                if (state == UPDATE_DR) begin
                    user_update <= user_sel;
                    for (int n = 0; n < NUM_USER_DR; n++)
                        if (user_sel[n]) user_dr_out[n*DR_WIDTH +: DR_WIDTH] <= dr_sh;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_sampled_tap.sv
// tb_jtag_sampled_tap: directed + randomized scans of jtag_sampled_tap against a scan-level reference model.
module tb_jtag_sampled_tap;

    logic        clk = 0, rst_n = 0, tck = 0, tms = 0, tdi = 0;
    logic        tdo, tdo_oe;
    logic [3:0]  tap_state;
    logic [4:0]  instruction;
    logic [63:0] user_dr_in = '0, user_dr_out;
    logic [1:0]  user_capture, user_update;

    jtag_sampled_tap dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tck         (tck),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_oe      (tdo_oe),
        .tap_state   (tap_state),
        .instruction (instruction),
        .user_dr_in  (user_dr_in),
        .user_dr_out (user_dr_out),
        .user_capture(user_capture),
        .user_update (user_update)
    );

    always #5 clk = ~clk;

    int n_asrt = 0, n_fail = 0;
    int cap_cnt[2] = '{0, 0};
    int upd_cnt[2] = '{0, 0};
    int multi = 0;

    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            cap_cnt[n] += int'(user_capture[n]);
            upd_cnt[n] += int'(user_update[n]);
        end
        if ($countones({user_capture, user_update}) > 1) multi++;
    end

    // reference model: 1149.1 transition table {tms=0, tms=1} plus scan-level register contents
    int nxt[16][2] = '{'{1,0}, '{1,2}, '{3,9}, '{4,5}, '{4,5}, '{6,8}, '{6,7}, '{4,8},
                       '{1,2}, '{10,0}, '{11,12}, '{11,12}, '{13,15}, '{13,14}, '{11,15}, '{1,2}};
    int          m_state = 0;
    logic [4:0]  m_ir = 5'd1;
    logic [31:0] m_out[2] = '{0, 0};
    int          m_cap[2] = '{0, 0};
    int          m_upd[2] = '{0, 0};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one tck period; returns tdo as seen just before the rising edge
    task automatic tclk(input logic ms, input logic di, output logic dout);
        tms = ms;
        tdi = di;
        repeat (5) @(negedge clk);
        dout = tdo;
        tck = 1;
        m_state = nxt[m_state][ms];
        if (m_state == 0) m_ir = 5'd1;
        repeat (5) @(negedge clk);
        tck = 0;
        chk("tap_state", 128'(tap_state), 128'(m_state));
    endtask

    task automatic move(input logic [15:0] seq, input int n);
        logic d;
        for (int i = 0; i < n; i++) tclk(seq[i], 1'b0, d);
    endtask

    task automatic scan_ir(input logic [4:0] v);
        logic [4:0] got;
        logic d;
        move(16'b0011, 4);
        for (int i = 0; i < 5; i++) begin
            tclk(i == 4, v[i], d);
            got[i] = d;
        end
        move(16'b01, 2);
        m_ir = v;
        chk("ir_capture", 128'(got), 128'(5'b00001));
        chk("instruction", 128'(instruction), 128'(v));
    endtask

    task automatic dr_bits(input int n, input logic [127:0] din, input logic last, output logic [127:0] dout);
        logic b;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            tclk(last && i == n - 1, din[i], b);
            dout[i] = b;
        end
    endtask

    function automatic int uidx(input logic [4:0] ir);
        return ir == 5'd8 ? 0 : ir == 5'd9 ? 1 : -1;
    endfunction

    function automatic logic [127:0] capv(input logic [4:0] ir);
        int u = uidx(ir);
        return u >= 0 ? 128'(user_dr_in[u*32 +: 32]) : ir == 5'd1 ? 128'(32'h1000_563D) : 128'd0;
    endfunction

    task automatic check_counts(input string tag);
        chk({tag, "_caps"}, {64'd0, 32'(cap_cnt[1]), 32'(cap_cnt[0])}, {64'd0, 32'(m_cap[1]), 32'(m_cap[0])});
        chk({tag, "_upds"}, {64'd0, 32'(upd_cnt[1]), 32'(upd_cnt[0])}, {64'd0, 32'(m_upd[1]), 32'(m_upd[0])});
    endtask

    // full DR scan from Run-Test/Idle: the register behaves as capture value with din queued behind it
    task automatic scan_dr(input int n, input logic [127:0] din, input string tag);
        int u = uidx(m_ir);
        int w = (u >= 0 || m_ir == 5'd1) ? 32 : 1;
        logic [127:0] stream, mask, got;
        stream = (din << w) | capv(m_ir);
        mask = (128'd1 << n) - 1;
        move(16'b001, 3);
        dr_bits(n, din, 1'b1, got);
        move(16'b01, 2);
        if (u >= 0) begin
            m_out[u] = stream[n +: 32];
            m_cap[u]++;
            m_upd[u]++;
        end
        chk({tag, "_tdo"}, got & mask, stream & mask);
        chk({tag, "_out"}, 128'(user_dr_out), 128'({m_out[1], m_out[0]}));
        check_counts(tag);
    endtask

    initial begin
        logic [127:0] g1, g2;
        logic [31:0]  v;
        logic [4:0]   ir;
        logic d;
        repeat (3) @(negedge clk);
        chk("rst_state", 128'(tap_state), 128'd0);
        chk("rst_instr", 128'(instruction), 128'd1);
        chk("rst_tdo", 128'({tdo, tdo_oe}), 128'd0);
        chk("rst_out", 128'({user_dr_out, user_capture, user_update}), 128'd0);
        rst_n = 1;
        move(16'b11111, 5);
        move(16'b0, 1);
        repeat (5) @(negedge clk);
        chk("idle_state", 128'(tap_state), 128'd1);
        chk("idle_instr", 128'(instruction), 128'd1);
        chk("idle_oe", 128'(tdo_oe), 128'd0);
        repeat (50) @(negedge clk);
        chk("frozen", 128'(tap_state), 128'd1);

        scan_dr(32, '0, "idcode");

        // asynchronous reset in the middle of a USER0 shift
        scan_ir(5'b01000);
        user_dr_in = {$urandom, $urandom};
        move(16'b001, 3);
        m_cap[0]++;
        dr_bits(8, 128'hA5, 1'b0, g1);
        rst_n = 0;
        @(negedge clk);
        chk("midrst_state", 128'(tap_state), 128'd0);
        chk("midrst_instr", 128'(instruction), 128'd1);
        chk("midrst_out", 128'(user_dr_out), 128'({m_out[1], m_out[0]}));
        chk("midrst_oe", 128'({tdo, tdo_oe}), 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        m_state = 0;
        m_ir = 5'd1;
        move(16'b0, 1);
        check_counts("midrst");

        // five tms=1 from Shift-IR
        move(16'b0011, 4);
        tclk(1'b0, 1'b1, d);
        move(16'b11111, 5);
        chk("tms_reset_instr", 128'(instruction), 128'd1);
        move(16'b0, 1);

        scan_ir(5'b11111);
        scan_dr(4, 128'b1, "bypass");

        user_dr_in[63:32] = 32'hCAFE_F00D;
        scan_ir(5'b01001);
        scan_dr(32, 128'h1234_5678, "user1");

        // USER0 split by a 10-tck Pause-DR
        scan_ir(5'b01000);
        v = $urandom;
        move(16'b001, 3);
        dr_bits(16, 128'(v[15:0]), 1'b1, g1);
        move(16'b0, 10);
        move(16'b01, 2);
        dr_bits(16, 128'(v[31:16]), 1'b1, g2);
        move(16'b01, 2);
        chk("pause_tdo", 128'({g2[15:0], g1[15:0]}), 128'(user_dr_in[31:0]));
        m_out[0] = v;
        m_cap[0]++;
        m_upd[0]++;
        chk("pause_out", 128'(user_dr_out), 128'({m_out[1], m_out[0]}));
        check_counts("pause");

        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 4))
                0: ir = 5'd1;
                1: ir = 5'd8;
                2: ir = 5'd9;
                3: ir = 5'd31;
                default: begin
                    do ir = 5'($urandom_range(0, 31)); while (ir == 1 || ir == 8 || ir == 9 || ir == 31);
                end
            endcase
            user_dr_in = {$urandom, $urandom};
            scan_ir(ir);
            scan_dr(int'($urandom_range(1, 40)), {64'd0, $urandom, $urandom}, "rand");
        end

        chk("one_hot_pulses", 128'(multi), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_sampled_tap.md
Name: jtag_sampled_tap

Overview:
- IEEE 1149.1 TAP controller that runs entirely in the system clock domain. tck, tms and tdi are oversampled and edge-detected.
- Generalises the team's TAP with a configurable IDCODE, a real 1-bit BYPASS, and NUM_USER_DR independent user data registers selected by instruction.
- Sits between the board JTAG pins and on-chip debug/config logic. The system side sees single-clock pulses only; no tck-domain logic.

Parameters:
- IR_WIDTH, 5, instruction register width (min 4).
- DR_WIDTH, 32, width of the IDCODE and each user DR.
- NUM_USER_DR, 2, number of user DR channels (1..8).
- IDCODE_VALUE, 32'h1000_563D, IDCODE capture value (bit0 must be 1); zero-extended or truncated to DR_WIDTH.
- SYNC_STAGES, 2, synchroniser depth on tck/tms/tdi (min 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tck  in  1  JTAG test clock (asynchronous, sampled)
- tms  in  1  JTAG test mode select
- tdi  in  1  JTAG test data in
- tdo  out  1  JTAG test data out
- tdo_oe  out  1  tdo output enable
- tap_state  out  4  current TAP state, same 0x0..0xF encoding as the existing TAP
- instruction  out  IR_WIDTH  active instruction
- user_dr_in  in  NUM_USER_DR*DR_WIDTH  capture data, channel n at [n*DR_WIDTH +: DR_WIDTH]
- user_dr_out  out  NUM_USER_DR*DR_WIDTH  updated data, same slicing
- user_capture  out  NUM_USER_DR  1-clk pulse per channel at Capture-DR
- user_update  out  NUM_USER_DR  1-clk pulse per channel at Update-DR

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). Reset values:
  - tap_state = TEST_LOGIC_RESET, instruction = IDCODE (00001)
  - tdo = 0, tdo_oe = 0
  - user_dr_out = 0, user_capture = 0, user_update = 0
  - all synchronisers = 0
- Sampling: tck/tms/tdi pass through SYNC_STAGES flops. One extra flop on synced tck gives tck_rise (0->1) and tck_fall (1->0) one-clk pulses. Pin edge to pulse latency = SYNC_STAGES+1 clk. tck high and low time must each be >= SYNC_STAGES+2 clk. tms/tdi are used as sampled together with tck_rise.
- TAP FSM: standard 16-state 1149.1 graph. Advances only on tck_rise, using synced tms. Five tck_rise with tms=1 reach TEST_LOGIC_RESET from any state. No tck edges -> all state frozen.
- Test-Logic-Reset: entering it forces instruction = IDCODE on the same clk.
- Instruction decode:
  - all-ones = BYPASS
  - 00001 = IDCODE
  - 01000+n = USERn, for n < NUM_USER_DR
  - any other code behaves as BYPASS; instruction still reports the raw code.
- IR path:
  - Capture-IR on tck_rise loads 0..01 (LSBs "01").
  - Shift-IR on tck_rise shifts right with tdi entering the MSB.
  - Update-IR on tck_fall copies the shift reg to instruction.
- DR path, single DR_WIDTH shift reg plus separate 1-bit bypass reg:
  - Capture-DR on tck_rise loads: bypass=0; IDCODE=IDCODE_VALUE; USERn=user_dr_in slice n. user_capture[n] pulses on that same clk for USERn.
  - Shift-DR on tck_rise: bypass takes tdi; otherwise shift right with tdi into the MSB.
  - Update-DR on tck_fall, USERn only: user_dr_out slice n <= shift reg, and user_update[n] pulses on the same clk. IDCODE and BYPASS updates are ignored.
- TDO:
  - Updates on tck_fall. In Shift-IR/Shift-DR, tdo = LSB of the selected shift reg (bypass bit for BYPASS).
  - tdo_oe is set on tck_fall in Shift-IR/Shift-DR and cleared on tck_fall in any other state. tdo is 0 while tdo_oe = 0.
- Boundaries:
  - A short shift (fewer than DR_WIDTH bits) updates with the partially shifted register as-is.
  - Over-length shift: the earliest bits fall out on tdo.
  - Pause-DR/Exit2 and back to Shift-DR preserve the shift reg.
  - At most one of user_capture/user_update is high per clk, and never more than one channel.
  - rst_n asserted mid-shift aborts immediately to reset values; user_dr_out is not updated.

Optional Feature:
- Macro JTAG_SAMPLED_TAP_TRST_EN.
- Defined: adds input trst_n (1 bit, asynchronous active-low). It is synchronised (SYNC_STAGES) and, while low, forces TEST_LOGIC_RESET and instruction = IDCODE. tdo/tdo_oe are held 0. user_dr_out is untouched.
- Undefined: no port; reset is via rst_n and the TMS=1 sequence only.

Decomposition:
- Shared package jtag_pkg:
  - 4-bit TAP state localparams (same encoding as the existing TAP)
  - BYPASS/IDCODE/USER_BASE instruction constants
  - next-state function
- One sub-module, jtag_pin_sync: SYNC_STAGES synchroniser for tck/tms/tdi plus tck_rise/tck_fall detection. Also reused for trst_n.

Test Plan:
- Reset then 5 tck with tms=1, then tms=0 -> tap_state=RUN_TEST_IDLE (1), instruction=00001, tdo_oe=0.
- Default-IDCODE DR scan of 32 bits, tdi=0 -> tdo bits LSB-first read 0x1000563D; user_update stays 0.
- IR scan 11111, then DR scan of 1 bit 1 followed by 0s -> tdo shows 0 then 1 (one-bit delay); user_dr_out unchanged.
- IR=01001 (USER1), user_dr_in[63:32]=0xCAFEF00D, shift in 0x12345678 -> tdo reads 0xCAFEF00D; user_capture[1] one pulse; user_update[1] one pulse; user_dr_out[63:32]=0x12345678; channel 0 still 0.
- USER0 shift of 16 bits, Pause-DR for 10 tck, resume 16 bits -> user_dr_out[31:0] equals the 32-bit value as if shifted contiguously.
- rst_n low during Shift-DR after 8 bits -> tap_state=0, instruction=00001, user_dr_out unchanged from its previous value, no user_update pulse.
